// File: rtl/npc_ctrl_if.sv
// Fetch and load/store handshake bundle between the NPC sequencer and its IFU/LSU.
// The sequencer is the master: it raises the requests and consumes the responses.
interface npc_ctrl_if;
  logic        ifu_req;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_req;
  logic        lsu_wen;
  logic        lsu_done;

  modport master (
    output ifu_req,
    input  ifu_rvalid,
    input  ifu_rdata,
    output lsu_req,
    output lsu_wen,
    input  lsu_done
  );

  modport slave (
    input  ifu_req,
    output ifu_rvalid,
    output ifu_rdata,
    input  lsu_req,
    input  lsu_wen,
    output lsu_done
  );
endinterface

// File: rtl/npc_ctrl.sv
// Multi-cycle sequencer for the single-issue NPC core: FETCH -> EXEC -> [MEM] -> WB,
// with HALT on ebreak and ERROR on a memory-response timeout.
module npc_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  npc_ctrl_if.master       bus,
  output logic [31:0]      inst,
  input  logic             dec_mem_ren,
  input  logic             dec_mem_wen,
  input  logic             dec_reg_wen,
  input  logic             dec_halt,
  output logic             pc_wen,
  output logic             reg_wen,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halted,
  output logic             err
);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic              rst_hold;
  logic              wen_q;
  logic              load_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      rst_hold   <= 1'b1;
      inst       <= NOP;
      retire_cnt <= '0;
      wait_cnt   <= '0;
      wen_q      <= 1'b0;
    end else begin
      state    <= state_n;
      rst_hold <= 1'b0;
      wait_cnt <= wait_n;
      if (load_inst)        inst       <= bus.ifu_rdata;
      // An illegal load+store decode collapses to a store.
      if (state == S_EXEC)  wen_q      <= dec_mem_wen;
      if (state == S_WB)    retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // rst_hold keeps the first post-reset cycle quiet so ifu_req only rises
  // once rst has actually dropped.
  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    load_inst = 1'b0;
    case (state)
      S_FETCH: begin
        if (!rst_hold) begin
          if (bus.ifu_rvalid) begin
            load_inst = 1'b1;
            state_n   = S_EXEC;
            wait_n    = '0;
          end else if (wait_cnt == WAIT_MAX) begin
            state_n = S_ERROR;
            wait_n  = '0;
          end else begin
            wait_n = wait_cnt + WAIT_W'(1);
          end
        end
      end
      S_EXEC: begin
        if (dec_halt)                        state_n = S_HALT;
        else if (dec_mem_ren || dec_mem_wen) state_n = S_MEM;
        else                                 state_n = S_WB;
      end
      S_MEM: begin
        if (bus.lsu_done) begin
          state_n = S_WB;
          wait_n  = '0;
        end else if (wait_cnt == WAIT_MAX) begin
          state_n = S_ERROR;
          wait_n  = '0;
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      S_WB:    state_n = S_FETCH;
      S_HALT:  state_n = S_HALT;
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_ERROR;
    endcase
  end

  // Outputs decode state/registers only; no response input reaches them.
  assign bus.ifu_req = (state == S_FETCH) && !rst_hold;
  assign bus.lsu_req = (state == S_MEM);
  assign bus.lsu_wen = (state == S_MEM) && wen_q;
  assign pc_wen      = (state == S_WB);
  assign retire      = (state == S_WB);
  assign reg_wen     = (state == S_WB) && dec_reg_wen && !wen_q;
  assign halted      = (state == S_HALT);
  assign err         = (state == S_ERROR);

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed bench for npc_ctrl: a tiny opcode decoder plus per-scenario tasks
// with hand-computed expectations, sampled on the falling edge.
module tb_npc_ctrl;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      inst;
  logic             dec_mem_ren, dec_mem_wen, dec_reg_wen, dec_halt;
  logic             pc_wen, reg_wen, retire, halted, err;
  logic [CNT_W-1:0] retire_cnt;
  logic             both;
  int               n_chk = 0;
  int               n_pass = 0;

  npc_ctrl_if bus ();

  npc_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .inst        (inst),
    .dec_mem_ren (dec_mem_ren),
    .dec_mem_wen (dec_mem_wen),
    .dec_reg_wen (dec_reg_wen),
    .dec_halt    (dec_halt),
    .pc_wen      (pc_wen),
    .reg_wen     (reg_wen),
    .retire      (retire),
    .retire_cnt  (retire_cnt),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Minimal RV32I decoder; 'both' forces the illegal load+store combination.
  always_comb begin
    dec_mem_ren = (inst[6:0] == 7'b0000011) || both;
    dec_mem_wen = (inst[6:0] == 7'b0100011) || both;
    dec_halt    = (inst == 32'h0010_0073);
    dec_reg_wen = !((inst[6:0] == 7'b0100011) || (inst[6:0] == 7'b1100011) ||
                    (inst[6:0] == 7'b1110011));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // From a FETCH cycle: deliver one instruction with rvalid in the first cycle.
  task automatic fetch(input logic [31:0] w);
    bus.ifu_rvalid = 1'b1;
    bus.ifu_rdata  = w;
    step();
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rdata  = 32'hdead_beef;
  endtask

  task automatic run_nop();
    fetch(32'h0000_0013);
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_chk++; if (bus.ifu_req !== 1'b0) $display("FAIL reset_ifu_req got=%b want=0", bus.ifu_req); else n_pass++;
    n_chk++; if ({bus.lsu_req, pc_wen, reg_wen, retire, halted, err} !== 6'b0)
      $display("FAIL reset_strobes got=%b want=000000", {bus.lsu_req, pc_wen, reg_wen, retire, halted, err}); else n_pass++;
    n_chk++; if (inst !== 32'h0000_0013) $display("FAIL reset_inst got=%h want=00000013", inst); else n_pass++;
    n_chk++; if (retire_cnt !== 4'd0) $display("FAIL reset_cnt got=%0d want=0", retire_cnt); else n_pass++;
    rst = 1'b0;
    step();
    n_chk++; if (bus.ifu_req !== 1'b1) $display("FAIL reset_first_fetch got=%b want=1", bus.ifu_req); else n_pass++;
  endtask

  task automatic test_alu();
    fetch(32'h0050_0093);
    n_chk++; if ({bus.ifu_req, pc_wen, inst} !== {2'b00, 32'h0050_0093})
      $display("FAIL alu_exec got=%b%b/%h want=00/00500093", bus.ifu_req, pc_wen, inst); else n_pass++;
    step();
    n_chk++; if ({pc_wen, reg_wen, retire} !== 3'b111)
      $display("FAIL alu_wb got=%b want=111", {pc_wen, reg_wen, retire}); else n_pass++;
    step();
    n_chk++; if ({bus.ifu_req, pc_wen, retire_cnt} !== {2'b10, 4'd1})
      $display("FAIL alu_refetch got=%b%b cnt=%0d want=10 cnt=1", bus.ifu_req, pc_wen, retire_cnt); else n_pass++;
  endtask

  task automatic test_load();
    int req_cycles = 0;
    fetch(32'h0000_a103);
    step();
    for (int i = 0; i < 3; i++) begin
      if (bus.lsu_req === 1'b1 && bus.lsu_wen === 1'b0) req_cycles++;
      if (i == 2) bus.lsu_done = 1'b1;
      step();
    end
    bus.lsu_done = 1'b0;
    n_chk++; if (req_cycles != 3) $display("FAIL load_req_cycles got=%0d want=3", req_cycles); else n_pass++;
    n_chk++; if ({bus.lsu_req, pc_wen, reg_wen} !== 3'b011)
      $display("FAIL load_wb got=%b want=011", {bus.lsu_req, pc_wen, reg_wen}); else n_pass++;
    step();
    n_chk++; if ({bus.ifu_req, retire_cnt} !== {1'b1, 4'd2})
      $display("FAIL load_done got=%b cnt=%0d want=1 cnt=2", bus.ifu_req, retire_cnt); else n_pass++;
  endtask

  task automatic test_store(input logic force_both, input logic [31:0] w, input logic [3:0] cnt_exp);
    both = force_both;
    fetch(w);
    step();
    n_chk++; if ({bus.lsu_req, bus.lsu_wen} !== 2'b11)
      $display("FAIL store_mem both=%b got=%b want=11", force_both, {bus.lsu_req, bus.lsu_wen}); else n_pass++;
    bus.lsu_done = 1'b1;
    step();
    bus.lsu_done = 1'b0;
    n_chk++; if ({pc_wen, reg_wen, bus.lsu_req} !== 3'b100)
      $display("FAIL store_wb both=%b got=%b want=100", force_both, {pc_wen, reg_wen, bus.lsu_req}); else n_pass++;
    step();
    both = 1'b0;
    n_chk++; if (retire_cnt !== cnt_exp)
      $display("FAIL store_cnt both=%b got=%0d want=%0d", force_both, retire_cnt, cnt_exp); else n_pass++;
  endtask

  task automatic test_halt();
    int bad = 0;
    for (int i = 0; i < 6; i++) run_nop();
    fetch(32'h0010_0073);
    n_chk++; if (halted !== 1'b0) $display("FAIL halt_exec got=%b want=0", halted); else n_pass++;
    step();
    n_chk++; if ({halted, retire_cnt} !== {1'b1, 4'd10})
      $display("FAIL halt_enter got=%b cnt=%0d want=1 cnt=10", halted, retire_cnt); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      bus.ifu_rvalid = i[0];
      bus.lsu_done   = i[1];
      step();
      if (bus.ifu_req !== 1'b0 || pc_wen !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) bad++;
    end
    bus.ifu_rvalid = 1'b0;
    bus.lsu_done   = 1'b0;
    n_chk++; if (bad != 0) $display("FAIL halt_hold bad_cycles=%0d want=0", bad); else n_pass++;
    n_chk++; if (retire_cnt !== 4'd10) $display("FAIL halt_cnt got=%0d want=10", retire_cnt); else n_pass++;
  endtask

  task automatic test_timeout();
    int fetch_cycles = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (bus.ifu_req === 1'b1 && err === 1'b0) fetch_cycles++;
      step();
    end
    n_chk++; if (fetch_cycles != 8) $display("FAIL timeout_fetch_cycles got=%0d want=8", fetch_cycles); else n_pass++;
    n_chk++; if ({err, bus.ifu_req} !== 2'b10) $display("FAIL timeout_err got=%b want=10", {err, bus.ifu_req}); else n_pass++;
    fetch(32'h0050_0093);
    step();
    n_chk++; if ({err, bus.ifu_req, pc_wen, inst} !== {3'b100, 32'h0000_0013})
      $display("FAIL timeout_late_rvalid got=%b/%h want=100/00000013", {err, bus.ifu_req, pc_wen}, inst); else n_pass++;
    apply_reset();
    n_chk++; if ({err, bus.ifu_req} !== 2'b01) $display("FAIL timeout_recover got=%b want=01", {err, bus.ifu_req}); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) run_nop();
    n_chk++; if (retire_cnt !== 4'd0) $display("FAIL wrap_16 got=%0d want=0", retire_cnt); else n_pass++;
    run_nop();
    n_chk++; if (retire_cnt !== 4'd1) $display("FAIL wrap_17 got=%0d want=1", retire_cnt); else n_pass++;
  endtask

  task automatic test_rst_mid_mem();
    int bad = 0;
    fetch(32'h0000_a103);
    step();
    n_chk++; if (bus.lsu_req !== 1'b1) $display("FAIL midmem_req got=%b want=1", bus.lsu_req); else n_pass++;
    rst = 1'b1;
    step();
    n_chk++; if ({bus.lsu_req, bus.ifu_req, retire_cnt} !== {2'b00, 4'd0})
      $display("FAIL midmem_reset got=%b cnt=%0d want=00 cnt=0", {bus.lsu_req, bus.ifu_req}, retire_cnt); else n_pass++;
    rst = 1'b0;
    step();
    bus.lsu_done = 1'b1;
    step();
    bus.lsu_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (pc_wen !== 1'b0 || bus.ifu_req !== 1'b1 || bus.lsu_req !== 1'b0) bad++;
      step();
    end
    n_chk++; if (bad != 0) $display("FAIL midmem_stray_done bad_cycles=%0d want=0", bad); else n_pass++;
    n_chk++; if (inst !== 32'h0000_0013) $display("FAIL midmem_inst got=%h want=00000013", inst); else n_pass++;
  endtask

  initial begin
    rst            = 1'b1;
    both           = 1'b0;
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rdata  = 32'h0;
    bus.lsu_done   = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store(1'b0, 32'h0020_a223, 4'd3);
    test_store(1'b1, 32'h0000_0013, 4'd4);
    test_halt();
    test_timeout();
    test_wrap();
    test_rst_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
